amplitude_detector: RTL

- Receive-side counterpart of the waveform amplitude-selection path.
- Observes the 8-bit scaled sample stream that leaves the amplitude-selection stage, which applies a right shift of 0..3.
- Measures max, min and peak-to-peak over a window of valid samples.
- Decodes the 2-bit amplitude setting that produced the stream. Used by the lab bench and the display logic to confirm the selected amplitude.

---
 rtl/amplitude_detector.sv | 128 ++++++++++++
 1 files changed

// File: rtl/amplitude_detector.sv
// amplitude_detector: measures max, min and peak-to-peak over a window of valid
// samples and decodes the amplitude shift that produced the stream.
module amplitude_detector #(
  parameter int WINDOW = 256,
  parameter int CNT_W  = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sample_valid,
  input  logic [7:0] data_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] peak_out,
  output logic [7:0] min_out,
  output logic [7:0] ptp_out,
  output logic [1:0] amp_sel_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    REPORT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

  state_t           state_r;
  state_t           next_state_s;
  logic             accept_s;
  logic [7:0]       max_r;
  logic [7:0]       min_r;
  logic [CNT_W-1:0] count_r;

  // Each right shift halves full scale, so the highest set bit of max names the shift.
  function automatic logic [1:0] decode_amp(input logic [7:0] mx);
    logic [1:0] sel;
    if (mx[7]) begin
      sel = 2'b00;
    end else if (mx[6]) begin
      sel = 2'b01;
    end else if (mx[5]) begin
      sel = 2'b10;
    end else begin
      sel = 2'b11;
    end
    return sel;
  endfunction

  assign busy = (state_r != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state selection; the window closes on the WINDOW-th accepted sample.
  always_comb begin
    next_state_s = state_r;
    accept_s     = sample_valid && (state_r == MEASURE);
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = MEASURE;
        end else begin
          next_state_s = IDLE;
        end
      end
      MEASURE: begin
        if (accept_s && (count_r == LAST_CNT)) begin
          next_state_s = REPORT;
        end else begin
          next_state_s = MEASURE;
        end
      end
      REPORT:  next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Running extremes, sample count and the registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_r       <= 8'h00;
      min_r       <= 8'hFF;
      count_r     <= '0;
      done        <= 1'b0;
      peak_out    <= 8'h00;
      min_out     <= 8'h00;
      ptp_out     <= 8'h00;
      amp_sel_out <= 2'b11;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            max_r   <= 8'h00;
            min_r   <= 8'hFF;
            count_r <= '0;
          end
        end
        MEASURE: begin
          if (accept_s) begin
            if (data_in > max_r) max_r <= data_in;
            if (data_in < min_r) min_r <= data_in;
            count_r <= count_r + CNT_W'(1);
          end
        end
        REPORT: begin
          // At least one sample was taken, so max_r >= min_r here.
          peak_out    <= max_r;
          min_out     <= min_r;
          ptp_out     <= max_r - min_r;
          amp_sel_out <= decode_amp(max_r);
          done        <= 1'b1;
        end
        default: begin
          count_r <= '0;
        end
      endcase
    end
  end

endmodule
